sd_block_dma: RTL and testbench
===============================

# sd_block_dma

Block-transfer engine that sits directly upstream of the SD-card storage port (real or fake SD image). Given a file number, block address, direction and a processor-RAM base address, it issues one load/store operation to the SD port, waits for `op_complete`, then streams all 256 words of the block between the SD port and a 1-cycle-latency processor RAM port. It frees the CPU from per-word SD transfers and signals completion with a single-cycle `done` pulse.

## Interface
- `BLOCK_WORDS`, 256: words per block; must equal the 8-bit `addr_proc` range.
- `TIMEOUT_CYCLES`, 1023: maximum cycles spent in WAIT_OP; only used when `SD_DMA_TIMEOUT_EN` is defined.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  command strobe; sampled only in IDLE.
- `dir`  in  1  0 = load (SD→RAM), 1 = store (RAM→SD).
- `cmd_file`  in  16  file number.
- `cmd_block`  in  16  block address; only bits [7:0] are used by the SD port.
- `ram_base`  in  16  first RAM word address.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse in the DONE state.
- `err`  out  1  valid with `done`; 1 = SD operation timed out.
- `load_op`, `stor_op`  out  1  one-cycle SD operation request.
- `file_no`, `block_addr`  out  16  latched command values, held constant from ISSUE through DONE.
- `addr_proc`  out  8  SD word index.
- `we_proc`  out  1  SD write enable.
- `wd_proc`  out  16  SD write data.
- `io_q`  in  16  SD read data; valid the cycle after `addr_proc` is presented.
- `op_complete`  in  1  SD operation acknowledge.
- `ram_addr`  out  16  RAM address.
- `ram_we`  out  1  RAM write enable.
- `ram_wd`  out  16  RAM write data.
- `ram_q`  in  16  RAM read data; valid the cycle after `ram_addr` is presented.

## Operation
- States: IDLE, ISSUE, WAIT_OP, XFER, DONE.
- IDLE: when `start`=1, latch `dir`, `cmd_file`, `cmd_block` and `ram_base`, clear the index, then go to ISSUE. `start` in any other state is ignored.
- ISSUE (1 cycle): assert `load_op` if `dir`=0, otherwise `stor_op`. Then go to WAIT_OP.
- WAIT_OP: stay until `op_complete`=1, then go to XFER. An `op_complete` that arrives during ISSUE is not counted.
- XFER: the index runs 0..255 on `addr_proc`, one word per cycle, followed by one drain cycle (257 cycles total). Then go to DONE.
  - Load: write phase lags the index by one cycle, with `ram_we`=1, `ram_addr`=`ram_base`+index_d, `ram_wd`=`io_q`.
  - Store: `ram_addr`=`ram_base`+index in the same cycle as `addr_proc`=index. The next cycle drives `we_proc`=1 and `wd_proc`=`ram_q`. This alignment is required because the SD port registers its address one cycle before a write commits.
- DONE (1 cycle): `done`=1, then return to IDLE.
- `ram_base`+index wraps modulo 2^16.
- `cmd_file` is passed through unmodified; the SD port ignores the upper bits.
- Reset value of every output: 0. State resets to IDLE. A reset mid-transfer abandons the transfer with no `done` pulse; partial writes remain.

## Timing
- All outputs are registered.
- With `start` sampled at edge 0 and an SD port that returns `op_complete` one cycle after the request:
  - ISSUE is cycle 1.
  - WAIT_OP is cycle 2.
  - `addr_proc`=0..255 occupies cycles 3..258.
  - Writes (`ram_we` or `we_proc`) occupy cycles 4..259.
  - `done` is asserted in cycle 260.
- Throughput: 1 word/cycle. No back-to-back overlap; the next `start` is accepted in cycle 261 at the earliest.

## Configuration
- `SD_DMA_TIMEOUT_EN` defined: a watchdog counts cycles in WAIT_OP. When the count reaches `TIMEOUT_CYCLES`, go to DONE with `err`=1 and skip XFER; no RAM/SD writes occur.
- `SD_DMA_TIMEOUT_EN` undefined: WAIT_OP waits indefinitely, and `err` is tied to 0.

## Structure
- Package `sd_dma_pkg`:
  - state enum;
  - `DIR_LOAD`=0 and `DIR_STORE`=1;
  - `SD_BLOCK_WORDS`=256.
- Sub-module `sd_dma_watchdog`: a loadable down-counter with `expired` output, instantiated only under `SD_DMA_TIMEOUT_EN`.

## Test plan
- Load: SD file 2, block 3, word j = 16'hA000+j; start with `dir`=0, `ram_base`=16'h4000 → RAM[16'h4000+j]=16'hA000+j for all j. Expect `done` in cycle 260, `err`=0, and exactly 256 `ram_we` cycles.
- Store: RAM[16'h1000+j]=16'h5A00+j; start with `dir`=1, file 1, block 7 → SD word j of file 1, block 7 = 16'h5A00+j. Word 0 is correct, which checks address/write alignment.
- Wrap: `ram_base`=16'hFF80 on a load → words 0..127 land at 16'hFF80..16'hFFFF and words 128..255 at 16'h0000..16'h007F.
- Ignore start: `start` pulsed during XFER → no extra `load_op`, exactly one `done` pulse.
- Reset: `rst` asserted in cycle 100 of XFER → next cycle has all outputs 0 and the state is IDLE. A fresh load afterwards completes correctly.
- Timeout (`SD_DMA_TIMEOUT_EN`, `TIMEOUT_CYCLES`=15): `op_complete` held 0 → `done`=1 with `err`=1 after 15 WAIT_OP cycles, and no `ram_we` is ever asserted.

Source files
------------

// File: rtl/sd_dma_pkg.sv
// Shared types and constants for the SD block DMA engine (sd_block_dma).
package sd_dma_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWaitOp,
      StXfer,
      StDone
   } dma_state_e;

   localparam logic        DIR_LOAD       = 1'b0;
   localparam logic        DIR_STORE      = 1'b1;
   localparam int unsigned SD_BLOCK_WORDS = 256;
   localparam int unsigned IDX_W          = 9;

   // RAM word address for a block index; wraps modulo 2^16.
   function automatic logic [15:0] ram_word_addr(input logic [15:0] base,
                                                 input logic [IDX_W-1:0] idx);
      return base + {7'd0, idx};
   endfunction

endpackage

// File: rtl/sd_dma_watchdog.sv
// Loadable down-counter guarding the wait for the SD operation acknowledge.
module sd_dma_watchdog #(
   parameter int unsigned Count = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int unsigned W = $clog2(Count + 1);

   logic [W-1:0] cnt_q, cnt_d;

   // Loaded with Count-1 so expiry lands on the Count-th enabled cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = W'(Count - 1);
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/sd_block_dma.sv
// Block transfer engine between the SD storage port and processor RAM.
// Optional WAIT_OP watchdog enabled by defining SD_DMA_TIMEOUT_EN.
module sd_block_dma
   import sd_dma_pkg::*;
#(
   parameter int unsigned BLOCK_WORDS    = SD_BLOCK_WORDS,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        dir,
   input  logic [15:0] cmd_file,
   input  logic [15:0] cmd_block,
   input  logic [15:0] ram_base,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        load_op,
   output logic        stor_op,
   output logic [15:0] file_no,
   output logic [15:0] block_addr,
   output logic [7:0]  addr_proc,
   output logic        we_proc,
   output logic [15:0] wd_proc,
   input  logic [15:0] io_q,
   input  logic        op_complete,
   output logic [15:0] ram_addr,
   output logic        ram_we,
   output logic [15:0] ram_wd,
   input  logic [15:0] ram_q
);

   localparam logic [IDX_W-1:0] IdxEnd  = IDX_W'(BLOCK_WORDS);
   localparam logic [IDX_W-1:0] IdxLast = IDX_W'(BLOCK_WORDS - 1);

   dma_state_e       state_q, state_d;
   logic             dir_q, dir_d;
   logic [15:0]      base_q, base_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             load_op_q, load_op_d;
   logic             stor_op_q, stor_op_d;
   logic [15:0]      file_no_q, file_no_d;
   logic [15:0]      block_addr_q, block_addr_d;
   logic [7:0]       addr_proc_q, addr_proc_d;
   logic             we_proc_q, we_proc_d;
   logic [15:0]      ram_addr_q, ram_addr_d;
   logic             ram_we_q, ram_we_d;

   logic wd_load, wd_en, wd_expired;

`ifdef SD_DMA_TIMEOUT_EN
   sd_dma_watchdog #(
      .Count(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .load   (wd_load),
      .en     (wd_en),
      .expired(wd_expired)
   );
`else
   logic unused_wd;
   assign unused_wd  = ^{wd_load, wd_en, TIMEOUT_CYCLES};
   assign wd_expired = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      dir_d        = dir_q;
      base_d       = base_q;
      idx_d        = idx_q;
      busy_d       = busy_q;
      file_no_d    = file_no_q;
      block_addr_d = block_addr_q;
      addr_proc_d  = addr_proc_q;
      ram_addr_d   = ram_addr_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      load_op_d    = 1'b0;
      stor_op_d    = 1'b0;
      we_proc_d    = 1'b0;
      ram_we_d     = 1'b0;
      wd_load      = 1'b0;
      wd_en        = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d      = StIssue;
               dir_d        = dir;
               base_d       = ram_base;
               file_no_d    = cmd_file;
               block_addr_d = cmd_block;
               idx_d        = '0;
               busy_d       = 1'b1;
               load_op_d    = (dir == DIR_LOAD);
               stor_op_d    = (dir == DIR_STORE);
            end
         end

         StIssue: begin
            state_d = StWaitOp;
            wd_load = 1'b1;
         end

         StWaitOp: begin
            wd_en = 1'b1;
            if (op_complete) begin
               state_d     = StXfer;
               idx_d       = '0;
               addr_proc_d = '0;
               ram_addr_d  = base_q;
            end else if (wd_expired) begin
               state_d = StDone;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end
         end

         StXfer: begin
            if (idx_q != IdxEnd) begin
               idx_d = idx_q + 1'b1;
               if (idx_q != IdxLast) begin
                  addr_proc_d = idx_q[7:0] + 8'd1;
               end
               // Load writes word idx_q to RAM next cycle; store commits word idx_q to
               // SD next cycle while RAM is already addressed for the following word.
               if (dir_q == DIR_LOAD) begin
                  ram_we_d   = 1'b1;
                  ram_addr_d = ram_word_addr(base_q, idx_q);
               end else begin
                  we_proc_d  = 1'b1;
                  ram_addr_d = ram_word_addr(base_q, idx_q + 1'b1);
               end
            end else begin
               state_d = StDone;
               done_d  = 1'b1;
            end
         end

         StDone: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         dir_q        <= DIR_LOAD;
         base_q       <= '0;
         idx_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         load_op_q    <= 1'b0;
         stor_op_q    <= 1'b0;
         file_no_q    <= '0;
         block_addr_q <= '0;
         addr_proc_q  <= '0;
         we_proc_q    <= 1'b0;
         ram_addr_q   <= '0;
         ram_we_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         base_q       <= base_d;
         idx_q        <= idx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         load_op_q    <= load_op_d;
         stor_op_q    <= stor_op_d;
         file_no_q    <= file_no_d;
         block_addr_q <= block_addr_d;
         addr_proc_q  <= addr_proc_d;
         we_proc_q    <= we_proc_d;
         ram_addr_q   <= ram_addr_d;
         ram_we_q     <= ram_we_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign load_op    = load_op_q;
   assign stor_op    = stor_op_q;
   assign file_no    = file_no_q;
   assign block_addr = block_addr_q;
   assign addr_proc  = addr_proc_q;
   assign we_proc    = we_proc_q;
   assign ram_addr   = ram_addr_q;
   assign ram_we     = ram_we_q;
   // Read data flows straight through in the write cycle so each word moves at 1/cycle.
   assign wd_proc    = we_proc_q ? ram_q : 16'h0000;
   assign ram_wd     = ram_we_q ? io_q : 16'h0000;

endmodule

// File: tb/tb_sd_block_dma.sv
// Scoreboard bench for sd_block_dma with SD-port and RAM models.
`timescale 1ns/1ps
module tb_sd_block_dma;
   import sd_dma_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        dir = 1'b0;
   logic [15:0] cmd_file = '0, cmd_block = '0, ram_base = '0;
   logic        busy, done, err, load_op, stor_op, we_proc, ram_we;
   logic [15:0] file_no, block_addr, wd_proc, ram_addr, ram_wd;
   logic [7:0]  addr_proc;
   logic [15:0] io_q = '0, ram_q = '0;
   logic        op_complete = 1'b0;

   always #5 clk = ~clk;

   sd_block_dma #(.TIMEOUT_CYCLES(15)) dut (
      .clk(clk), .rst(rst), .start(start), .dir(dir), .cmd_file(cmd_file),
      .cmd_block(cmd_block), .ram_base(ram_base), .busy(busy), .done(done), .err(err),
      .load_op(load_op), .stor_op(stor_op), .file_no(file_no), .block_addr(block_addr),
      .addr_proc(addr_proc), .we_proc(we_proc), .wd_proc(wd_proc), .io_q(io_q),
      .op_complete(op_complete), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wd(ram_wd),
      .ram_q(ram_q)
   );

   // ---------------- environment models ----------------
   logic [15:0] ram_mem [0:65535];
   logic [15:0] sd_mem [int unsigned];
   logic [7:0]  sd_addr_r = '0;
   bit          sd_resp_en = 1'b1;
   int          cyc = 0;

   function automatic int unsigned sd_key(input logic [15:0] f, input logic [15:0] b,
                                          input logic [7:0] w);
      return {8'h00, f[7:0], b[7:0], w};
   endfunction

   function automatic logic [15:0] sd_rd(input int unsigned k);
      return sd_mem.exists(k) ? sd_mem[k] : 16'h0000;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      ram_q <= ram_mem[ram_addr];
      io_q <= sd_rd(sd_key(file_no, block_addr, addr_proc));
      if (ram_we) ram_mem[ram_addr] = ram_wd;
      if (we_proc) sd_mem[sd_key(file_no, block_addr, sd_addr_r)] = wd_proc;
      sd_addr_r <= addr_proc;
      op_complete <= sd_resp_en && (load_op || stor_op);
   end

   // ---------------- scoreboard ----------------
   typedef struct { logic [31:0] addr; logic [15:0] data; int cyc; } wr_t;
   typedef struct { logic store; int cyc; } op_t;
   typedef struct { logic err; int cyc; } dn_t;
   wr_t ram_exp[$];
   wr_t sd_exp[$];
   op_t op_exp[$];
   dn_t done_exp[$];

   int checks = 0, failures = 0, n_ram_we = 0, n_done = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      wr_t w;
      op_t o;
      dn_t d;
      if (!rst) begin
         if (load_op || stor_op) begin
            if (op_exp.size() == 0) check("spurious_op", {30'd0, stor_op, load_op}, 32'd0);
            else begin
               o = op_exp.pop_front();
               check("op_kind", {30'd0, stor_op, load_op}, o.store ? 32'd2 : 32'd1);
               check("op_cycle", cyc, o.cyc);
            end
         end
         if (ram_we) begin
            n_ram_we++;
            if (ram_exp.size() == 0) check("spurious_ram_we", {31'd0, ram_we}, 32'd0);
            else begin
               w = ram_exp.pop_front();
               check("ram_wr_addr", {16'd0, ram_addr}, w.addr);
               check("ram_wr_data", {16'd0, ram_wd}, {16'd0, w.data});
               check("ram_wr_cycle", cyc, w.cyc);
            end
         end
         if (we_proc) begin
            if (sd_exp.size() == 0) check("spurious_we_proc", {31'd0, we_proc}, 32'd0);
            else begin
               w = sd_exp.pop_front();
               check("sd_wr_key", sd_key(file_no, block_addr, sd_addr_r), w.addr);
               check("sd_wr_data", {16'd0, wd_proc}, {16'd0, w.data});
               check("sd_wr_cycle", cyc, w.cyc);
            end
         end
         if (done) begin
            n_done++;
            check("busy_at_done", {31'd0, busy}, 32'd1);
            if (done_exp.size() == 0) check("spurious_done", {31'd0, done}, 32'd0);
            else begin
               d = done_exp.pop_front();
               check("done_err", {31'd0, err}, {31'd0, d.err});
               check("done_cycle", cyc, d.cyc);
            end
         end
      end
   end

   // Reference: one op request in cycle 1, word j moved in cycle 4+j, done in cycle 260.
   task automatic expect_xfer(input int c, input logic d, input logic [15:0] f,
                              input logic [15:0] b, input logic [15:0] base);
      op_exp.push_back('{store: d, cyc: c + 1});
      for (int j = 0; j < 256; j++) begin
         logic [15:0] a;
         a = base + 16'(j);
         if (d == DIR_LOAD)
            ram_exp.push_back('{addr: {16'd0, a}, data: sd_rd(sd_key(f, b, 8'(j))),
                                cyc: c + 4 + j});
         else
            sd_exp.push_back('{addr: sd_key(f, b, 8'(j)), data: ram_mem[a], cyc: c + 4 + j});
      end
      done_exp.push_back('{err: 1'b0, cyc: c + 260});
   endtask

   task automatic issue(input logic d, input logic [15:0] f, input logic [15:0] b,
                        input logic [15:0] base, input bit with_model, output int c);
      @(negedge clk);
      c = cyc;
      start = 1'b1; dir = d; cmd_file = f; cmd_block = b; ram_base = base;
      if (with_model) expect_xfer(c, d, f, b, base);
      @(negedge clk);
      start = 1'b0;
      cmd_file = 16'($urandom); cmd_block = 16'($urandom); ram_base = 16'($urandom);
      check("busy_after_start", {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_done(input int target, input int limit);
      int k = 0;
      while (n_done < target && k < limit) begin
         @(negedge clk);
         k++;
      end
      check("done_seen", n_done, target);
   endtask

   task automatic run_xfer(input logic d, input logic [15:0] f, input logic [15:0] b,
                           input logic [15:0] base);
      int c, we0, dn0, mism;
      logic [15:0] want [0:255];
      for (int j = 0; j < 256; j++)
         want[j] = (d == DIR_LOAD) ? sd_rd(sd_key(f, b, 8'(j))) : ram_mem[16'(base + 16'(j))];
      we0 = n_ram_we;
      dn0 = n_done;
      issue(d, f, b, base, 1'b1, c);
      wait_done(dn0 + 1, 400);
      check("ram_we_count", n_ram_we - we0, (d == DIR_LOAD) ? 256 : 0);
      mism = 0;
      for (int j = 0; j < 256; j++) begin
         logic [15:0] got;
         got = (d == DIR_LOAD) ? ram_mem[16'(base + 16'(j))] : sd_rd(sd_key(f, b, 8'(j)));
         if (got !== want[j]) mism++;
      end
      check("block_contents", mism, 0);
   endtask

   initial begin
      int c, dn0, we0;
      for (int i = 0; i < 65536; i++) ram_mem[i] = 16'($urandom);
      for (int j = 0; j < 256; j++) sd_mem[sd_key(16'd2, 16'd3, 8'(j))] = 16'hA000 + 16'(j);
      for (int j = 0; j < 256; j++) ram_mem[16'h1000 + 16'(j)] = 16'h5A00 + 16'(j);

      repeat (3) @(negedge clk);
      check("rst_ctl", {25'd0, busy, done, err, load_op, stor_op, we_proc, ram_we}, 32'd0);
      check("rst_cmd", {file_no, block_addr}, 32'd0);
      check("rst_sd", {8'd0, addr_proc, wd_proc}, 32'd0);
      check("rst_ram", {ram_addr, ram_wd}, 32'd0);
      rst = 1'b0;

      run_xfer(DIR_LOAD, 16'd2, 16'd3, 16'h4000);
      run_xfer(DIR_STORE, 16'd1, 16'd7, 16'h1000);
      check("store_word0", {16'd0, sd_rd(sd_key(16'd1, 16'd7, 8'd0))}, 32'h5A00);
      run_xfer(DIR_LOAD, 16'd2, 16'd3, 16'hFF80);
      check("wrap_word127", {16'd0, ram_mem[16'hFFFF]}, 32'hA07F);
      check("wrap_word128", {16'd0, ram_mem[16'h0000]}, 32'hA080);

      // start pulsed mid-transfer must be ignored
      dn0 = n_done;
      issue(DIR_LOAD, 16'd2, 16'd3, 16'h2000, 1'b1, c);
      while (cyc < c + 50) @(negedge clk);
      start = 1'b1; dir = DIR_STORE;
      @(negedge clk);
      start = 1'b0;
      wait_done(dn0 + 1, 400);
      repeat (20) @(negedge clk);
      check("single_done", n_done - dn0, 1);

      // reset during XFER abandons the transfer
      dn0 = n_done;
      issue(DIR_LOAD, 16'd2, 16'd3, 16'h3000, 1'b1, c);
      while (cyc < c + 103) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      ram_exp.delete(); sd_exp.delete(); op_exp.delete(); done_exp.delete();
      @(negedge clk);
      check("midrst_ctl", {25'd0, busy, done, err, load_op, stor_op, we_proc, ram_we}, 32'd0);
      check("midrst_bus", {file_no, block_addr}, 32'd0);
      check("midrst_data", {8'd0, addr_proc, ram_addr}, 32'd0);
      check("midrst_state", {29'd0, dut.state_q}, {29'd0, StIdle});
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("midrst_no_done", n_done - dn0, 0);
      run_xfer(DIR_LOAD, 16'd2, 16'd3, 16'h3000);

      // randomized transfers
      for (int t = 0; t < 4; t++) begin
         logic [15:0] f, b;
         f = 16'($urandom);
         b = 16'($urandom);
         for (int j = 0; j < 256; j++) sd_mem[sd_key(f, b, 8'(j))] = 16'($urandom);
         run_xfer(1'($urandom), f, b, 16'($urandom));
      end

`ifdef SD_DMA_TIMEOUT_EN
      sd_resp_en = 1'b0;
      dn0 = n_done;
      we0 = n_ram_we;
      issue(DIR_LOAD, 16'd2, 16'd3, 16'h6000, 1'b0, c);
      op_exp.push_back('{store: 1'b0, cyc: c + 1});
      done_exp.push_back('{err: 1'b1, cyc: c + 17});
      wait_done(dn0 + 1, 100);
      check("timeout_no_we", n_ram_we - we0, 0);
      sd_resp_en = 1'b1;
`else
      we0 = 0;
`endif

      repeat (5) @(negedge clk);
      check("queues_drained", ram_exp.size() + sd_exp.size() + op_exp.size() + done_exp.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: sim time limit reached, checks=%0d", checks);
      $fatal(1);
   end

endmodule
